re_lod_norm_pipe: RTL
=====================

Name: re_lod_norm_pipe

Overview:
Parametrised, pipelined leading-one detector with mantissa normalisation for the logarithmic multiplier datapath. For each operand it produces the leading-one position k, a zero flag, and the FRAC_W bits immediately below the leading one, left-aligned. The result is the integer and fraction parts of a Mitchell log2 approximation. The block has two register stages with a valid/ready handshake and sits between operand capture and the log-domain adder.

Parameters:
WIDTH, 32, operand width in bits; must be at least 2.
K_W, $clog2(WIDTH), width of out_k.
FRAC_W, 8, fraction width; 1 <= FRAC_W <= WIDTH-1.
TAG_W, 4, width of the sideband tag carried alongside each operand.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
in_valid  in  1  operand present.
in_ready  out  1  block accepts the operand this cycle.
in_num  in  WIDTH  unsigned operand.
in_tag  in  TAG_W  sideband tag, passed through unchanged.
out_valid  out  1  result present.
out_ready  in  1  downstream accepts the result this cycle.
out_k  out  K_W  leading-one index; bit 0 is the LSB.
out_frac  out  FRAC_W  bits below the leading one, MSB-aligned.
out_zero  out  1  set when in_num == 0.
out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While rst_n=0:
  - out_valid=0, out_k=0, out_frac=0, out_zero=0, out_tag=0.
  - All internal valid bits are cleared; all internal data registers are 0.
- Reset asserted mid-operation discards every in-flight operand. No output appears after release until a new operand is accepted.
- Transfers: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid & out_ready.
- Stage 1 (S1) captures from the input: k = index of the highest set bit of in_num; zero = (in_num==0); tag; and the raw operand.
  - For in_num=0: k=0 and zero=1.
  - For in_num=1: k=0 and zero=0.
- Stage 2 (S2) drives the outputs and computes the fraction:
  - Form t = num << (WIDTH-1-k), truncated to WIDTH bits.
  - Truncated fraction: frac = t[WIDTH-2 : WIDTH-1-FRAC_W].
  - When k < FRAC_W, the low bits of frac are zero-filled.
  - When zero=1, frac=0.
- Advance rules:
  - S2 loads when S1 is valid and (!out_valid | out_ready).
  - S1 loads when in_valid and (!S1_valid | S2 loads).
  - in_ready = !S1_valid | S2_loads. This is a combinational path from out_ready, which is accepted.
- Latency and throughput:
  - An operand accepted at edge n appears with out_valid=1 after edge n+1, provided out_ready was high.
  - Throughput is 1 operand per cycle when out_ready is held high.
- Backpressure: while out_valid & !out_ready, the outputs out_k, out_frac, out_zero and out_tag hold stable. The pipeline holds at most 2 operands; with both stages full, in_ready=0.
- Simultaneous events: with a full pipeline, an output transfer and an input transfer in the same cycle both complete. No bubble is inserted and no operand is lost or duplicated.
- Ordering: results leave strictly in acceptance order; out_tag identifies each one.

Optional Feature:
Macro RE_LOD_ROUND_EN.
- Defined, applies only when k > FRAC_W:
  - guard = t[WIDTH-2-FRAC_W]; frac is rounded half-up by adding guard.
  - If the addition carries out of FRAC_W bits and k < WIDTH-1: out_k = k+1 and out_frac = 0.
  - If it carries out and k == WIDTH-1: the result saturates to out_k = WIDTH-1, out_frac = all ones.
- Undefined: frac is truncated as in Behaviour and no guard logic is instantiated.
- Latency and the handshake are identical in both builds.

Test Plan:
1. Reset, then in_num=0x00000B00, tag=3, out_ready=1 -> two edges after accept: k=11, frac=0x60, zero=0, tag=3.
2. in_num=0 then in_num=1 -> first result k=0, zero=1, frac=0; second result k=0, zero=0, frac=0.
3. in_num=0x000003FF -> without RE_LOD_ROUND_EN: k=9, frac=0xFF. With it: k=10, frac=0x00.
4. in_num=0xFFFFFFFF with RE_LOD_ROUND_EN -> k=31, frac=0xFF (saturated). Without it: the same values via truncation.
5. Stream of 6 operands with out_ready held low for 4 cycles:
   - in_ready drops after 2 accepts and the outputs hold stable.
   - After release, all 6 results arrive in order with matching tags, at one per cycle.
6. Assert rst_n=0 with 2 operands in flight -> out_valid=0 immediately. After release, no stale result is emitted.

Source files
------------

// File: rtl/re_lod_norm_pipe.sv
// Two-stage leading-one detector and mantissa normaliser producing Mitchell log2 (k, frac).
// Optional round-half-up of the fraction is enabled by defining RE_LOD_ROUND_EN.
module re_lod_norm_pipe #(
    parameter int WIDTH  = 32,
    parameter int K_W    = $clog2(WIDTH),
    parameter int FRAC_W = 8,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_num,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [K_W-1:0]    out_k,
    output logic [FRAC_W-1:0] out_frac,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag
);

    function automatic logic [K_W-1:0] lead_one(input logic [WIDTH-1:0] n);
        logic [K_W-1:0] k;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (n[i]) k = K_W'(i);
        end
        return k;
    endfunction

    // Shift the leading one to the MSB; the FRAC_W bits beneath it are the fraction.
    function automatic logic [FRAC_W-1:0] trunc_frac(input logic [WIDTH-1:0] n,
                                                     input logic [K_W-1:0]   k);
        logic [WIDTH-1:0] t;
        t = n << (K_W'(WIDTH - 1) - k);
        return t[WIDTH-2 -: FRAC_W];
    endfunction

`ifdef RE_LOD_ROUND_EN
    localparam int GIDX = (WIDTH - 2 - FRAC_W >= 0) ? (WIDTH - 2 - FRAC_W) : 0;

    function automatic logic guard_bit(input logic [WIDTH-1:0] n,
                                       input logic [K_W-1:0]   k);
        logic [WIDTH-1:0] t;
        t = n << (K_W'(WIDTH - 1) - k);
        return t[GIDX];
    endfunction

    // Carry out of the fraction bumps k; at the top index the result saturates instead.
    function automatic logic [K_W+FRAC_W-1:0] round_half_up(input logic [K_W-1:0]    k,
                                                            input logic [FRAC_W-1:0] frac,
                                                            input logic              guard);
        logic [FRAC_W:0]  sum;
        logic [K_W-1:0]   k_rnd;
        logic [FRAC_W-1:0] f_rnd;
        sum   = {1'b0, frac} + {{FRAC_W{1'b0}}, guard};
        k_rnd = k;
        f_rnd = sum[FRAC_W-1:0];
        if (sum[FRAC_W]) begin
            if (k == K_W'(WIDTH - 1)) begin
                f_rnd = '1;
            end else begin
                k_rnd = k + K_W'(1);
                f_rnd = '0;
            end
        end
        return {k_rnd, f_rnd};
    endfunction
`endif

    logic              vld_p1, vld_p2;
    logic [WIDTH-1:0]  num_p1;
    logic [K_W-1:0]    k_p1, k_p2;
    logic              zero_p1, zero_p2;
    logic [TAG_W-1:0]  tag_p1, tag_p2;
    logic [FRAC_W-1:0] frac_p2;
    logic              s1_load, s2_load;
    logic [K_W-1:0]    k_nxt;
    logic [FRAC_W-1:0] frac_nxt;

    assign s2_load  = vld_p1 & (~vld_p2 | out_ready);
    assign in_ready = ~vld_p1 | s2_load;
    assign s1_load  = in_valid & in_ready;

    always_comb begin
        k_nxt    = k_p1;
        frac_nxt = zero_p1 ? '0 : trunc_frac(num_p1, k_p1);
`ifdef RE_LOD_ROUND_EN
        if (!zero_p1 && (k_p1 > K_W'(FRAC_W))) begin
            {k_nxt, frac_nxt} = round_half_up(k_p1, frac_nxt, guard_bit(num_p1, k_p1));
        end
`endif
    end

    // Stage 1: leading-one index, zero flag and raw operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            num_p1  <= '0;
            k_p1    <= '0;
            zero_p1 <= 1'b0;
            tag_p1  <= '0;
        end else if (s1_load) begin
            vld_p1  <= 1'b1;
            num_p1  <= in_num;
            k_p1    <= lead_one(in_num);
            zero_p1 <= (in_num == '0);
            tag_p1  <= in_tag;
        end else if (s2_load) begin
            vld_p1  <= 1'b0;
        end
    end

    // Stage 2: normalised fraction and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            k_p2    <= '0;
            frac_p2 <= '0;
            zero_p2 <= 1'b0;
            tag_p2  <= '0;
        end else if (s2_load) begin
            vld_p2  <= 1'b1;
            k_p2    <= k_nxt;
            frac_p2 <= frac_nxt;
            zero_p2 <= zero_p1;
            tag_p2  <= tag_p1;
        end else if (out_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    assign out_valid = vld_p2;
    assign out_k     = k_p2;
    assign out_frac  = frac_p2;
    assign out_zero  = zero_p2;
    assign out_tag   = tag_p2;

endmodule
